// File: rtl/gcd_requester_if.sv
// gcd_requester_if
//   Handshake between the operand-issuing requester and the GCD unit.
//   master (requester): drives In_A, In_B, In_ready, Result_taken;
//                       samples Result_valid, Result.
//   slave  (GCD unit) : the mirror image.
interface gcd_requester_if #(
  parameter int numOfBits = 5
);
  logic [numOfBits-1:0] In_A;
  logic [numOfBits-1:0] In_B;
  logic                 In_ready;
  logic                 Result_valid;
  logic [numOfBits-1:0] Result;
  logic                 Result_taken;

  modport master (
    output In_A, In_B, In_ready, Result_taken,
    input  Result_valid, Result
  );

  modport slave (
    input  In_A, In_B, In_ready, Result_taken,
    output Result_valid, Result
  );
endinterface

// File: rtl/gcd_requester.sv
// gcd_requester
//   Buffers operand pairs from a host in a small circular FIFO, presents each
//   pair to a GCD unit, waits for the result, acknowledges it and forwards it
//   to the host as a one-cycle pulse. A watchdog raises a sticky Error when
//   the GCD unit fails to answer within TIMEOUT cycles of WAIT.
// Ports:
//   Clk, nrst         clock, synchronous active-low reset
//   Push/Push_A/B     host enqueue request and operands
//   Full              FIFO holds DEPTH pairs (pushes dropped)
//   gcd (master)      In_A/In_B/In_ready out, Result_valid/Result in,
//                     Result_taken out
//   Out_valid/Out_data one-cycle result pulse to the host
//   Busy              transaction in flight or FIFO non-empty
//   Error             sticky watchdog timeout flag
module gcd_requester #(
  parameter int numOfBits = 5,
  parameter int DEPTH     = 4,
  parameter int TIMEOUT   = 128
) (
  input  logic                 Clk,
  input  logic                 nrst,
  input  logic                 Push,
  input  logic [numOfBits-1:0] Push_A,
  input  logic [numOfBits-1:0] Push_B,
  output logic                 Full,
  gcd_requester_if.master      gcd,
  output logic                 Out_valid,
  output logic [numOfBits-1:0] Out_data,
  output logic                 Busy,
  output logic                 Error
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int PW = 2 * numOfBits;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, TAKE} state_e;

  state_e               state_q, state_d;
  logic [PW-1:0]        mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [WW-1:0]        wd_q, wd_d;
  logic [numOfBits-1:0] in_a_q, in_a_d;
  logic [numOfBits-1:0] in_b_q, in_b_d;
  logic [numOfBits-1:0] out_data_q, out_data_d;
  logic                 in_ready_q, in_ready_d;
  logic                 taken_q, taken_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy_q, busy_d;
  logic                 full_q, full_d;
  logic                 error_q, error_d;
  logic                 push_ok;
  logic                 pop;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    wd_d       = wd_q;
    in_a_d     = in_a_q;
    in_b_d     = in_b_q;
    out_data_d = out_data_q;
    error_d    = error_q;

    // Full is judged on the pre-edge count, so a pop in the same cycle
    // does not make room for a push.
    push_ok = Push && (count_q != CW'(DEPTH));
    pop     = (state_q == IDLE) && (count_q != '0);

    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      in_a_d   = mem_q[rd_ptr_q][PW-1:numOfBits];
      in_b_d   = mem_q[rd_ptr_q][numOfBits-1:0];
    end

    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    unique case (state_q)
      IDLE:  if (pop) state_d = ISSUE;
      ISSUE: begin
        state_d = WAIT;
        wd_d    = '0;
      end
      WAIT: begin
        if (gcd.Result_valid) begin
          out_data_d = gcd.Result;
          state_d    = TAKE;
        end else if (wd_q == WW'(TIMEOUT - 1)) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      TAKE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered copies of the next-state decode, which makes
    // them Moore outputs of the state register without extra latency.
    in_ready_d  = (state_d == ISSUE);
    taken_d     = (state_d == TAKE);
    out_valid_d = (state_d == TAKE);
    busy_d      = (state_d != IDLE) || (count_d != '0);
    full_d      = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge Clk) begin
    if (!nrst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wd_q        <= '0;
      in_a_q      <= '0;
      in_b_q      <= '0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b0;
      taken_q     <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      full_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wd_q        <= wd_d;
      in_a_q      <= in_a_d;
      in_b_q      <= in_b_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      taken_q     <= taken_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      full_q      <= full_d;
      error_q     <= error_d;
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge Clk) begin
    if (nrst && push_ok) mem_q[wr_ptr_q] <= {Push_A, Push_B};
  end

  assign gcd.In_A         = in_a_q;
  assign gcd.In_B         = in_b_q;
  assign gcd.In_ready     = in_ready_q;
  assign gcd.Result_taken = taken_q;
  assign Out_valid        = out_valid_q;
  assign Out_data         = out_data_q;
  assign Busy             = busy_q;
  assign Full             = full_q;
  assign Error            = error_q;

endmodule

// File: tb/tb_gcd_requester.sv
module tb_gcd_requester;
  localparam int W       = 5;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 128;

  logic         Clk = 1'b0;
  logic         nrst = 1'b0;
  logic         Push = 1'b0;
  logic [W-1:0] Push_A = '0;
  logic [W-1:0] Push_B = '0;
  logic         Full, Out_valid, Busy, Error;
  logic [W-1:0] Out_data;

  gcd_requester_if #(.numOfBits(W)) gif ();

  gcd_requester #(.numOfBits(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .Clk(Clk), .nrst(nrst), .Push(Push), .Push_A(Push_A), .Push_B(Push_B),
    .Full(Full), .gcd(gif.master), .Out_valid(Out_valid), .Out_data(Out_data),
    .Busy(Busy), .Error(Error)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;

  function automatic void check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [W-1:0] gcd_of(input logic [W-1:0] a, input logic [W-1:0] b);
    int x = a;
    int y = b;
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return W'(x);
  endfunction

  // ---------------- behavioural reference model ----------------
  // A transaction goes: popped (issue cycle) -> waiting -> take cycle -> idle.
  logic [2*W-1:0] m_q[$];
  bit             m_issue = 0, m_wait = 0, m_take = 0, m_err = 0, m_live = 0;
  int             m_age = 0;
  logic [W-1:0]   m_ina = '0, m_inb = '0, m_out = '0;

  always @(posedge Clk) begin
    bit             was_full;
    logic [2*W-1:0] hd;
    if (!nrst) begin
      m_q.delete();
      m_issue = 0; m_wait = 0; m_take = 0; m_err = 0; m_age = 0;
      m_ina = '0; m_inb = '0; m_out = '0;
    end else begin
      was_full = (m_q.size() == DEPTH);
      if (m_issue) begin
        m_issue = 0; m_wait = 1; m_age = 0;
      end else if (m_wait) begin
        m_age++;
        if (gif.Result_valid) begin
          m_out = gif.Result; m_wait = 0; m_take = 1;
        end else if (m_age == TIMEOUT) begin
          m_err = 1; m_wait = 0;
        end
      end else if (m_take) begin
        m_take = 0;
      end else if (m_q.size() > 0) begin
        hd = m_q.pop_front();
        m_ina = hd[2*W-1:W]; m_inb = hd[W-1:0]; m_issue = 1;
      end
      if (Push && !was_full) m_q.push_back({Push_A, Push_B});
    end
    m_live = 1;
  end

  // ---------------- per-cycle compare + event log ----------------
  int             cyc = 0;
  int             n_issue = 0, n_taken = 0, ir_cyc = 0, err_cyc = -1;
  logic [W-1:0]   outs[$];
  logic [2*W-1:0] iss[$];

  always @(negedge Clk) begin
    if (m_live) begin
      cyc++;
      check("Full",         int'(Full),             int'(m_q.size() == DEPTH));
      check("In_ready",     int'(gif.In_ready),     int'(m_issue));
      check("Result_taken", int'(gif.Result_taken), int'(m_take));
      check("Out_valid",    int'(Out_valid),        int'(m_take));
      check("Busy",         int'(Busy),  int'(m_issue || m_wait || m_take || m_q.size() > 0));
      check("Error",        int'(Error),            int'(m_err));
      check("In_A",         int'(gif.In_A),         int'(m_ina));
      check("In_B",         int'(gif.In_B),         int'(m_inb));
      check("Out_data",     int'(Out_data),         int'(m_out));
      if (gif.In_ready) begin
        n_issue++; ir_cyc = cyc; iss.push_back({gif.In_A, gif.In_B});
      end
      if (gif.Result_taken) n_taken++;
      if (Out_valid) outs.push_back(Out_data);
      if (Error && err_cyc < 0) err_cyc = cyc;
    end
  end

  // ---------------- GCD unit emulator ----------------
  bit           emu_stall = 0, emu_force = 0, emu_clear = 0, emu_init = 0, emu_pend = 0;
  int           emu_lat = 10, emu_cnt = 0;
  logic [W-1:0] emu_res = '0, emu_force_val = '0;

  always @(negedge Clk) begin
    if (!emu_init) begin
      gif.Result_valid = 1'b0; gif.Result = '0; emu_init = 1;
    end
    if (emu_clear) begin
      gif.Result_valid = 1'b0; emu_pend = 0;
    end else if (emu_force) begin
      gif.Result_valid = 1'b1; gif.Result = emu_force_val;
    end else begin
      if (gif.Result_taken) begin
        gif.Result_valid = 1'b0; emu_pend = 0;
      end
      if (gif.In_ready) begin
        emu_pend = 1; emu_res = gcd_of(gif.In_A, gif.In_B); emu_cnt = emu_lat;
        gif.Result_valid = 1'b0;
      end else if (emu_pend && !emu_stall && !gif.Result_valid) begin
        if (emu_cnt <= 1) begin
          gif.Result_valid = 1'b1; gif.Result = emu_res;
        end else emu_cnt--;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drv(input bit p, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge Clk); #1;
    Push = p; Push_A = a; Push_B = b;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drv(1'b0, '0, '0);
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    do begin drv(1'b0, '0, '0); n++; end while (Busy && n < max);
    check("wait_idle_reached", int'(Busy), 0);
  endtask

  task automatic wait_outvalid(input int max);
    int n = 0;
    do begin @(negedge Clk); n++; end while (!Out_valid && n < max);
    #1;
    check("wait_outvalid_reached", int'(Out_valid), 1);
  endtask

  task automatic emu_clear_pulse();
    @(negedge Clk); #1; emu_clear = 1;
    @(negedge Clk); #1; emu_clear = 0;
  endtask

  int             base_o, base_i, base_t, pc;
  logic [2*W-1:0] pair;

  initial begin : watchdog
    #1ms;
    $display("FAIL global_timeout: simulation did not finish, tests=%0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    // 1: reset with Push held high
    nrst = 1'b0; Push = 1'b1; Push_A = 5'd3; Push_B = 5'd7;
    @(negedge Clk); @(negedge Clk); #1;
    nrst = 1'b1; Push = 1'b0;
    base_i = n_issue;
    idle_cycles(5);
    check("t1_no_issue", n_issue - base_i, 0);

    // 2: single transaction, latency checks
    base_o = outs.size(); base_i = n_issue;
    emu_lat = 10;
    drv(1'b1, 5'd12, 5'd18); pc = cyc;
    drv(1'b0, '0, '0);
    wait_outvalid(50);
    wait_idle(20);
    check("t2_issue_cnt", n_issue - base_i, 1);
    check("t2_issue_lat", ir_cyc - pc, 2);
    pair = iss[iss.size()-1];
    check("t2_in_a", int'(pair[2*W-1:W]), 12);
    check("t2_in_b", int'(pair[W-1:0]), 18);
    check("t2_out_cnt", outs.size() - base_o, 1);
    check("t2_out", int'(outs[base_o]), 6);

    // 3: fill FIFO behind a stalled transaction, overflow push dropped
    base_o = outs.size();
    emu_stall = 1;
    drv(1'b1, 5'd9, 5'd6);
    idle_cycles(4);
    drv(1'b1, 5'd7, 5'd5);
    drv(1'b1, 5'd31, 5'd1);
    drv(1'b1, 5'd20, 5'd8);
    drv(1'b1, 5'd2, 5'd6);
    drv(1'b1, 5'd3, 5'd3);
    check("t3_full", int'(Full), 1);
    drv(1'b0, '0, '0);
    check("t3_still_full", int'(Full), 1);
    emu_stall = 0;
    wait_idle(400);
    check("t3_out_cnt", outs.size() - base_o, 5);
    check("t3_out0", int'(outs[base_o]),   3);
    check("t3_out1", int'(outs[base_o+1]), 1);
    check("t3_out2", int'(outs[base_o+2]), 1);
    check("t3_out3", int'(outs[base_o+3]), 4);
    check("t3_out4", int'(outs[base_o+4]), 2);

    // 4: GCD unit never answers -> timeout, then recovery
    emu_stall = 1; base_t = n_taken;
    drv(1'b1, 5'd10, 5'd4);
    begin
      int n = 0;
      do begin drv(1'b0, '0, '0); n++; end while (!Error && n < 400);
    end
    check("t4_error_set", int'(Error), 1);
    check("t4_error_delay", err_cyc - ir_cyc, TIMEOUT + 1);
    check("t4_no_taken", n_taken - base_t, 0);
    emu_clear_pulse();
    emu_stall = 0; base_o = outs.size();
    drv(1'b1, 5'd8, 5'd12);
    wait_idle(100);
    check("t4_recover_out", int'(outs[outs.size()-1]), 4);
    check("t4_error_sticky", int'(Error), 1);

    // 5: reset during WAIT with pairs queued and Result_valid held
    emu_stall = 1;
    drv(1'b1, 5'd6, 5'd9);
    drv(1'b1, 5'd14, 5'd21);
    drv(1'b1, 5'd25, 5'd10);
    idle_cycles(4);
    base_t = n_taken; base_i = n_issue; base_o = outs.size();
    @(negedge Clk); #1; nrst = 1'b0; emu_force = 1; emu_force_val = 5'd7;
    @(negedge Clk); @(negedge Clk); #1; nrst = 1'b1;
    idle_cycles(10);
    check("t5_no_taken", n_taken - base_t, 0);
    check("t5_no_issue", n_issue - base_i, 0);
    check("t5_no_out", outs.size() - base_o, 0);
    check("t5_error_cleared", int'(Error), 0);
    emu_force = 0; emu_stall = 0;
    emu_clear_pulse();

    // 6a: Result_valid high while idle and empty
    base_t = n_taken; base_o = outs.size();
    @(negedge Clk); #1; emu_force = 1; emu_force_val = 5'd9;
    idle_cycles(8);
    check("t6_idle_no_taken", n_taken - base_t, 0);
    check("t6_idle_no_out", outs.size() - base_o, 0);
    emu_force = 0;
    emu_clear_pulse();

    // 6b: push while Full on the same edge as a pop
    emu_stall = 1; base_o = outs.size(); base_i = n_issue;
    drv(1'b1, 5'd4, 5'd6);
    drv(1'b1, 5'd9, 5'd12);
    drv(1'b1, 5'd15, 5'd10);
    drv(1'b1, 5'd21, 5'd14);
    drv(1'b1, 5'd18, 5'd24);
    drv(1'b0, '0, '0);
    check("t6_full", int'(Full), 1);
    emu_stall = 0;
    wait_outvalid(50);
    drv(1'b1, 5'd30, 5'd5);
    drv(1'b0, '0, '0);
    check("t6_full_after_poppush", int'(Full), 0);
    wait_idle(400);
    check("t6_issue_cnt", n_issue - base_i, 5);
    check("t6_out_cnt", outs.size() - base_o, 5);
    check("t6_out0", int'(outs[base_o]),   2);
    check("t6_out4", int'(outs[base_o+4]), 6);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      emu_lat = $urandom_range(1, 20);
      drv(($urandom_range(0, 3) == 0), W'($urandom_range(0, 31)), W'($urandom_range(0, 31)));
    end
    wait_idle(3000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
